// File: rtl/panel_pkg.sv
// Shared definitions for the panel input conditioner: A1 key FSM encoding
// and default timing constants for synthesis and simulation builds.
package panel_pkg;

  // A1 key handling states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } a1_state_e;

  // Hardware timing: long enough to reject mechanical bounce at board clock.
  localparam int SYN_DEB_CYCLES   = 16;
  localparam int SYN_REPEAT_DELAY = 64;
  localparam int SYN_REPEAT_RATE  = 32;

  // Short timing for fast simulation runs.
  localparam int SIM_DEB_CYCLES   = 4;
  localparam int SIM_REPEAT_DELAY = 10;
  localparam int SIM_REPEAT_RATE  = 5;

  // Same symbol selection scheme as the clock divider: define PANEL_SIM
  // to build with the short simulation timing.
`ifdef PANEL_SIM
  localparam int DEF_DEB_CYCLES   = SIM_DEB_CYCLES;
  localparam int DEF_REPEAT_DELAY = SIM_REPEAT_DELAY;
  localparam int DEF_REPEAT_RATE  = SIM_REPEAT_RATE;
`else
  localparam int DEF_DEB_CYCLES   = SYN_DEB_CYCLES;
  localparam int DEF_REPEAT_DELAY = SYN_REPEAT_DELAY;
  localparam int DEF_REPEAT_RATE  = SYN_REPEAT_RATE;
`endif

  // Map a raw pin level to active-high, given the pin polarity.
  function automatic logic norm_level(input logic lvl, input logic active_low);
    return lvl ^ active_low;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-FF synchroniser, polarity normalisation and a
// stable-sample counter that moves the clean level only after DEB_CYCLES
// consecutive differing samples.
module debounce_cell
  import panel_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16,
  parameter bit RST_LVL    = 1'b0,
  parameter bit INVERT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             sample_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;

  // Two-stage synchroniser, resting at the inactive raw level in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RST_LVL;
      sync2_q <= RST_LVL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the clean level.
  always_comb begin
    sample_s = norm_level(sync2_q, INVERT);
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    if (sample_s != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = ~clean_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce counter and clean level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// Board switch/key front-end: debounces SW1, SW2, SW_choose and A1, emits
// an A1 press/repeat strobe, a mode-change strobe and a press counter.
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter bit A1_ACTIVE_LOW = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw1_raw,
  input  logic       sw2_raw,
  input  logic       swc_raw,
  input  logic       a1_raw,
  output logic       SW1,
  output logic       SW2,
  output logic       SW_choose,
  output logic       A1,
  output logic       a1_pulse,
  output logic       mode_chg,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sw1_c, sw2_c, swc_c, a1_c;

  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .RST_LVL(1'b0), .INVERT(1'b0))
    u_deb_sw1 (.clk(clk), .rst(rst), .raw_i(sw1_raw), .clean_o(sw1_c));
  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .RST_LVL(1'b0), .INVERT(1'b0))
    u_deb_sw2 (.clk(clk), .rst(rst), .raw_i(sw2_raw), .clean_o(sw2_c));
  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .RST_LVL(1'b0), .INVERT(1'b0))
    u_deb_swc (.clk(clk), .rst(rst), .raw_i(swc_raw), .clean_o(swc_c));
  // A1 synchroniser rests at the released raw level; polarity flips after it.
  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W), .RST_LVL(A1_ACTIVE_LOW),
                  .INVERT(A1_ACTIVE_LOW))
    u_deb_a1 (.clk(clk), .rst(rst), .raw_i(a1_raw), .clean_o(a1_c));

  logic             sw1_q, sw2_q, swc_q, a1_q;
  logic             mode_chg_q, mode_chg_d;
  logic             a1_pulse_q, a1_pulse_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  a1_state_e        state_q, state_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             a1_rise_s;
  logic             rpt_due_s;

  // Next-state logic: mode change wins over any pulse due this cycle.
  always_comb begin
    mode_chg_d = (sw1_c ^ sw1_q) | (sw2_c ^ sw2_q);
    a1_rise_s  = a1_c & ~a1_q;
    rpt_due_s  = (rpt_cnt_q == CNT_ONE);
    state_d    = state_q;
    rpt_cnt_d  = rpt_cnt_q;
    a1_pulse_d = 1'b0;
    if (mode_chg_d) begin
      state_d = ST_LOCKOUT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (a1_rise_s) begin
            a1_pulse_d = 1'b1;
            rpt_cnt_d  = DELAY_LD;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!a1_c) begin
            state_d = ST_IDLE;
          end else if (rpt_due_s) begin
            if (REPEAT_EN) begin
              a1_pulse_d = 1'b1;
              rpt_cnt_d  = RATE_LD;
              state_d    = ST_REPEAT;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            rpt_cnt_d = rpt_cnt_q - CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!a1_c) begin
            state_d = ST_IDLE;
          end else if (rpt_due_s) begin
            a1_pulse_d = 1'b1;
            rpt_cnt_d  = RATE_LD;
          end else begin
            rpt_cnt_d = rpt_cnt_q - CNT_ONE;
          end
        end
        ST_LOCKOUT: begin
          if (!a1_c) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOCKOUT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    press_cnt_d = press_cnt_q + {7'd0, a1_pulse_d};
  end

  // A1 key FSM with its repeat counter and registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rpt_cnt_q  <= '0;
      a1_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rpt_cnt_q  <= rpt_cnt_d;
      a1_pulse_q <= a1_pulse_d;
    end
  end

  // Registered clean levels, mode strobe and press counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw1_q       <= 1'b0;
      sw2_q       <= 1'b0;
      swc_q       <= 1'b0;
      a1_q        <= 1'b0;
      mode_chg_q  <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      sw1_q       <= sw1_c;
      sw2_q       <= sw2_c;
      swc_q       <= swc_c;
      a1_q        <= a1_c;
      mode_chg_q  <= mode_chg_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign SW1       = sw1_q;
  assign SW2       = sw2_q;
  assign SW_choose = swc_q;
  assign A1        = a1_q;
  assign a1_pulse  = a1_pulse_q;
  assign mode_chg  = mode_chg_q;
  assign press_cnt = press_cnt_q;

endmodule
